// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor: A - B returned as sign + BCD magnitude.
// One BCD digit is processed per clock, least-significant digit first. A
// negative ten's-complement result is turned into its magnitude by a second
// serial pass (0 - result).
//
// Handshake: start is sampled only while the FSM is in IDLE; the operands are
// latched on that edge. busy is high in every state other than IDLE, and done
// pulses for the single FIN cycle in which diff, sign and err are valid.
// Starts seen while busy (including the FIN cycle) are ignored.
module bcd_sub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  sign,
  output logic                  err,
  output logic [2:0]            dbg_state
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CHK  = 3'd1,
    S_SUB  = 3'd2,
    S_NEG  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            sign_q, sign_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            borrow_q, borrow_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [3:0]      op_x;
  logic [3:0]      op_y;
  logic [4:0]      step;

  // Select digit idx of a packed BCD word.
  function automatic logic [3:0] get_digit(input logic [W-1:0] v,
                                           input logic [CW-1:0] idx);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == CW'(i)) r = v[4*i +: 4];
    end
    return r;
  endfunction

  // Replace digit idx of a packed BCD word.
  function automatic logic [W-1:0] put_digit(input logic [W-1:0] v,
                                             input logic [CW-1:0] idx,
                                             input logic [3:0] d);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == CW'(i)) r[4*i +: 4] = d;
    end
    return r;
  endfunction

  // True when any digit of the word is not a legal BCD digit (> 9).
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // One decimal digit of x - y - bin. Returns {borrow_out, digit}; the digit
  // is corrected back into 0..9 by adding ten when the raw result goes
  // negative. For legal digits the raw result lies in -10..9, so bit 4 of the
  // 5-bit difference is exactly the borrow.
  function automatic logic [4:0] digit_sub(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic       bin);
    logic [4:0] t;
    t = {1'b0, x} - {1'b0, y} - {4'd0, bin};
    if (t[4]) return {1'b1, t[3:0] + 4'd10};
    else      return {1'b0, t[3:0]};
  endfunction

  // Digit-slice operands: SUB computes a_i - b_i, NEG computes 0 - diff_i.
  always_comb begin
    op_x = 4'd0;
    op_y = get_digit(diff_q, cnt_q);
    if (state_q == S_SUB) begin
      op_x = get_digit(a_q, cnt_q);
      op_y = get_digit(b_q, cnt_q);
    end
    step = digit_sub(op_x, op_y, borrow_q);
  end

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    sign_d   = sign_q;
    err_d    = err_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          diff_d   = '0;
          sign_d   = 1'b0;
          err_d    = 1'b0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_CHK;
        end
      end

      S_CHK: begin
        if (has_bad_digit(a_q) || has_bad_digit(b_q)) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_SUB;
        end
      end

      S_SUB: begin
        diff_d   = put_digit(diff_q, cnt_q, step[3:0]);
        borrow_d = step[4];
        if (cnt_q == LAST_DIGIT) begin
          cnt_d = '0;
          if (step[4]) begin
            // A < B: the result is a ten's complement, convert it.
            sign_d   = 1'b1;
            borrow_d = 1'b0;
            state_d  = S_NEG;
          end else begin
            state_d = S_FIN;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_NEG: begin
        diff_d   = put_digit(diff_q, cnt_q, step[3:0]);
        borrow_d = step[4];
        if (cnt_q == LAST_DIGIT) begin
          // The final borrow of 0 - x is always set here and carries no info.
          cnt_d    = '0;
          borrow_d = 1'b0;
          state_d  = S_FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      sign_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      sign_q   <= sign_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign diff      = diff_q;
  assign sign      = sign_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/bcd_sub_serial.md
Name: bcd_sub_serial

Overview:
Digit-serial, multi-digit packed-BCD subtractor. It computes A − B and returns the result as sign plus BCD magnitude, processing one BCD digit per clock, least-significant digit first. It is the subtraction counterpart to the team's gate-level BCD adder and sits beside it in the decimal arithmetic datapath. A start/busy/done handshake makes it usable by a sequencer or calculator controller.

Parameters:
DIGITS, 4, number of BCD digits per operand (≥1). Operand and result width is 4*DIGITS.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  4*DIGITS  minuend, packed BCD; digit 0 = bits [3:0]
b  input  4*DIGITS  subtrahend, packed BCD
busy  output  1  high in every state other than IDLE
done  output  1  one-cycle pulse when diff, sign and err are valid
diff  output  4*DIGITS  BCD magnitude of A − B
sign  output  1  1 when A < B (result negative)
err  output  1  1 when any input digit > 9

Behaviour:
- One clock. Reset is synchronous and active-high; ports are named clk and rst.
- Reset state is IDLE. All outputs reset to 0: busy, done, diff, sign, err.
- States:
  - IDLE: wait for start.
  - CHK: validate the latched operands.
  - SUB: one digit per cycle, DIGITS cycles.
  - NEG: one digit per cycle, DIGITS cycles.
  - FIN: one cycle.
- IDLE:
  - When start=1 at an edge, latch a and b and go to CHK.
  - At that start, clear diff, sign and err.
  - start=0 keeps the block in IDLE.
- CHK (1 cycle):
  - If any digit of either latched operand is > 9, set err=1, leave diff=0 and sign=0, and go to FIN.
  - Otherwise clear the borrow and digit counter and go to SUB.
- SUB, per digit i = 0..DIGITS−1:
  - t = a_i − b_i − borrow.
  - If t < 0: d_i = t + 10 and borrow = 1.
  - Else: d_i = t and borrow = 0.
  - d_i is always 0..9.
  - After digit DIGITS−1: if final borrow = 1, go to NEG with sign=1 and a cleared borrow; else go to FIN.
- NEG converts the ten's-complement result to magnitude:
  - Per digit: t = 0 − d_i − borrow, with the same correction rule as SUB.
  - Runs DIGITS cycles, then goes to FIN. The final borrow is discarded.
- FIN: done=1 for exactly this cycle, then return to IDLE.
- diff, sign and err are updated only by the datapath. They hold their values after done until the next accepted start.
- Latency, from the edge that samples start to the cycle where done is high:
  - DIGITS+2 cycles for a non-negative result.
  - 2*DIGITS+2 cycles for a negative result.
  - 2 cycles when err is set.
- With DIGITS=4 these are 6, 10 and 2 cycles.
- Boundaries:
  - start while busy is ignored and has no effect on the operation in flight.
  - start asserted in the FIN cycle is ignored; start is accepted on the next cycle in IDLE.
  - A = B gives diff=0 and sign=0; NEG is not entered.
  - A = 0, B = 99..9 gives diff = 99..9 and sign=1.
  - Negative zero is impossible: NEG is entered only when A < B.
  - rst during any state forces IDLE and all-zero outputs at that edge. No done pulse is produced for the aborted operation.
  - a and b may change freely after the start edge; only the latched copies are used.

Test Plan:
- DIGITS=4, a=0x4321, b=0x1234, start pulse → done 6 cycles later; diff=0x3087, sign=0, err=0; busy high for 5 cycles before done and during the done cycle.
- a=0x1234, b=0x4321 → done at cycle 10; diff=0x3087, sign=1.
- a=0x0000, b=0x0001 → diff=0x0001, sign=1. Then a=0x0000, b=0x9999 → diff=0x9999, sign=1.
- a=0x5000, b=0x5000 → diff=0x0000, sign=0, done at cycle 6. Also check the borrow chain: a=0x1000, b=0x0001 → diff=0x0999, sign=0.
- a=0x12A4, b=0x0001 → done at cycle 2 with err=1, diff=0, sign=0. Then a valid operation must clear err.
- Start an operation and re-assert start with new operands mid-operation → the original result is unaffected. Assert rst on cycle 3 → busy=0, done never pulses, outputs 0; a subsequent start completes correctly.
